// File: rtl/rvga_types_pkg.sv
// Shared rvga types: machine word, dmem responder FSM encoding, error read value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rvga_types;

  typedef logic [31:0] rvga_word;

  // Responder FSM: accept in IDLE, count down in WAIT, pulse completion in RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rvga_dmem_state_e;

  // Read data returned for an out-of-range read.
  localparam rvga_word RVGA_DMEM_ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/rvga_sram.sv
// Synchronous 1-read/1-write word array backing the dmem responder; no reset.
// Latency: write lands at the issuing edge; read data valid one edge after issue.
// Backpressure: none, one read and one write may be issued every cycle.
module rvga_sram
  import rvga_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          w_v_i,
  input  logic [AW-1:0] w_addr_i,
  input  rvga_word      w_data_i,
  input  logic          r_v_i,
  input  logic [AW-1:0] r_addr_i,
  output rvga_word      r_data_o
);

  rvga_word mem_q [DEPTH_WORDS];
  rvga_word r_data_q;

  // Array write and registered read; read data holds until the next read.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= w_data_i;
    end
    if (r_v_i) begin
      r_data_q <= mem_q[r_addr_i];
    end
  end

  assign r_data_o = r_data_q;

endmodule

// File: rtl/rvga_dmem_responder.sv
// Memory-side end of the core dmem interface: word RAM, range check, sticky error.
// Latency: completion pulse exactly LATENCY cycles after the accept cycle.
// Backpressure: one transaction outstanding; requests are ignored outside IDLE.
module rvga_dmem_responder
  import rvga_types::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     dmem_r_v_i,
  input  logic     dmem_w_v_i,
  input  rvga_word dmem_addr_i,
  input  rvga_word dmem_data_i,
  output rvga_word dmem_data_o,
  output logic     dmem_resp_v_o,
  output logic     err_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // WAIT is left when the counter is 0, so a LATENCY of N spends N-1 cycles in WAIT.
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  rvga_dmem_state_e state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             is_rd_q, is_rd_d;   // pending transaction is a read
  logic             rd_ok_q, rd_ok_d;   // pending read hit the RAM
  rvga_word         data_q, data_d;
  logic             err_q, err_d;

  logic [29:0] word_off;
  logic        in_range;
  logic        req;
  logic        accept;
  logic        sram_w_v;
  logic        sram_r_v;
  rvga_word    sram_rdata;
  rvga_word    rd_value;
  rvga_word    data_out;
  logic        resp_v;
  logic        unused_addr_lsb;

  // BASE_ADDR is word-aligned, so subtracting the word parts equals the byte
  // subtraction shifted right by 2; a wrap produces a huge offset and fails the test.
  assign word_off        = dmem_addr_i[31:2] - BASE_ADDR[31:2];
  assign in_range        = {2'b00, word_off} < 32'(DEPTH_WORDS);
  assign unused_addr_lsb = ^dmem_addr_i[1:0];

  assign req    = dmem_r_v_i | dmem_w_v_i;
  assign accept = (state_q == IDLE) & req;

  // Both request bits high is a write; out-of-range accesses never touch the RAM.
  assign sram_w_v = accept & dmem_w_v_i & in_range;
  assign sram_r_v = accept & ~dmem_w_v_i & in_range;

  rvga_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_sram (
    .clk_i    (clk_i),
    .w_v_i    (sram_w_v),
    .w_addr_i (word_off[AW-1:0]),
    .w_data_i (dmem_data_i),
    .r_v_i    (sram_r_v),
    .r_addr_i (word_off[AW-1:0]),
    .r_data_o (sram_rdata)
  );

  assign rd_value = rd_ok_q ? sram_rdata : RVGA_DMEM_ERR_RDATA;

  // Next-state, capture and output logic. Read data is driven straight from the
  // RAM register in RESP (it is ready even when LATENCY is 1) and held in data_q after.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_rd_d  = is_rd_q;
    rd_ok_d  = rd_ok_q;
    data_d   = data_q;
    err_d    = err_q;
    resp_v   = 1'b0;
    data_out = data_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          // Writes commit at this edge, so only the kind and range result are kept.
          is_rd_d = ~dmem_w_v_i;
          rd_ok_d = ~dmem_w_v_i & in_range;
          err_d   = err_q | ~in_range | (dmem_r_v_i & dmem_w_v_i);
          if (LATENCY == 1) begin
            state_d = RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // The core still holds its request here; it is deliberately not sampled.
        resp_v  = 1'b1;
        state_d = IDLE;
        if (is_rd_q) begin
          data_d   = rd_value;
          data_out = rd_value;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      is_rd_q <= 1'b0;
      rd_ok_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      rd_ok_q <= rd_ok_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign dmem_resp_v_o = resp_v;
  assign dmem_data_o   = data_out;
  assign err_o         = err_q;

endmodule

// File: tb/tb_rvga_dmem_responder.sv
// Bench for rvga_dmem_responder: four instances with LATENCY 2, 1, 7 and 4.
// Directed requests push expected responses; a monitor pops and compares on resp_v.
// Each instance has its own request lines and reset so timing can be checked per latency.
module tb_rvga_dmem_responder;
  import rvga_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  rst_n;
  logic [3:0]  r_v;
  logic [3:0]  w_v;
  logic [3:0]  resp;
  logic [3:0]  err;
  logic [31:0] addr_a [4];
  logic [31:0] wd_a   [4];
  logic [31:0] rd_a   [4];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          dut;
    int unsigned cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] hold_m [4];
  logic        err_m  [4];

  function automatic int unsigned lat_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 1 : (d == 2) ? 7 : 4;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 7 : 4;
    rvga_dmem_responder #(
      .DEPTH_WORDS (1024),
      .BASE_ADDR   (32'h0000_0000),
      .LATENCY     (LAT)
    ) u_dut (
      .clk_i         (clk),
      .rst_i         (rst_n[g]),
      .dmem_r_v_i    (r_v[g]),
      .dmem_w_v_i    (w_v[g]),
      .dmem_addr_i   (addr_a[g]),
      .dmem_data_i   (wd_a[g]),
      .dmem_data_o   (rd_a[g]),
      .dmem_resp_v_o (resp[g]),
      .err_o         (err[g])
    );
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard in dut, cycle, data, err.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (resp[d] === 1'b1) begin
        if (sbq.size() == 0 || sbq[0].dut != d) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp dut=%0d cycle=%0d got resp=1 want none", d, cyc);
        end else begin
          e = sbq.pop_front();
          chk($sformatf("resp_cycle_dut%0d", d), cyc, e.cyc);
          chk($sformatf("resp_data_dut%0d", d), rd_a[d], e.data);
          chk($sformatf("resp_err_dut%0d", d), {31'b0, err[d]}, {31'b0, e.err});
        end
      end
    end
  end

  // Request already on the lines this cycle: record expectation, wait, then release.
  task automatic wait_resp(input int d, input bit isrd, input logic [31:0] expd, input bit bad);
    exp_t e;
    bit   got;
    e.dut = d;
    e.cyc = cyc + lat_of(d);
    if (isrd) hold_m[d] = expd;
    e.data = hold_m[d];
    err_m[d] = err_m[d] | bad;
    e.err = err_m[d];
    sbq.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (resp[d] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout dut=%0d got no resp want resp by cycle %0d", d, e.cyc);
    end
    @(negedge clk);
    if (got && isrd) chk($sformatf("data_hold_dut%0d", d), rd_a[d], expd);
    r_v[d] = 1'b0;
    w_v[d] = 1'b0;
  endtask

  task automatic txn(input int d, input bit rdq, input bit wrq, input logic [31:0] a,
                     input logic [31:0] wdat, input logic [31:0] expd, input bit bad);
    r_v[d]    = rdq;
    w_v[d]    = wrq;
    addr_a[d] = a;
    wd_a[d]   = wdat;
    wait_resp(d, rdq & ~wrq, expd, bad);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 4'h0;
    r_v   = 4'h0;
    w_v   = 4'h0;
    for (int d = 0; d < 4; d++) begin
      addr_a[d] = '0;
      wd_a[d]   = '0;
      hold_m[d] = '0;
      err_m[d]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_resp_dut%0d", d), {31'b0, resp[d]}, 32'h0);
      chk($sformatf("rst_data_dut%0d", d), rd_a[d], 32'h0);
      chk($sformatf("rst_err_dut%0d", d), {31'b0, err[d]}, 32'h0);
    end
    rst_n = 4'hF;
    @(negedge clk);

    // LATENCY=2: preload word 5, read it, write/read 0x40 back-to-back.
    txn(0, 0, 1, 32'h0000_0014, 32'hCAFE_F00D, 32'h0, 0);
    txn(0, 1, 0, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 0);
    txn(0, 0, 1, 32'h0000_0040, 32'h1234_5678, 32'h0, 0);
    txn(0, 1, 0, 32'h0000_0040, 32'h0,         32'h1234_5678, 0);
    // Out of range: one past the end, and a wrapped address below the base.
    txn(0, 1, 0, 32'h0000_1000, 32'h0,         32'h0, 1);
    txn(0, 1, 0, 32'hFFFF_FFFC, 32'h0,         32'h0, 1);
    // Out-of-range write aliasing word 5 in its low bits must not land.
    txn(0, 0, 1, 32'h0000_1014, 32'hDEAD_BEEF, 32'h0, 1);
    txn(0, 1, 0, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 0);
    txn(0, 1, 0, 32'h0000_0040, 32'h0,         32'h1234_5678, 0);

    // LATENCY=1: held back-to-back reads, then simultaneous r_v/w_v.
    txn(1, 0, 1, 32'h0000_0000, 32'h1111_1111, 32'h0, 0);
    txn(1, 1, 0, 32'h0000_0000, 32'h0,         32'h1111_1111, 0);
    txn(1, 1, 0, 32'h0000_0000, 32'h0,         32'h1111_1111, 0);
    txn(1, 1, 0, 32'h0000_0000, 32'h0,         32'h1111_1111, 0);
    txn(1, 1, 1, 32'h0000_0008, 32'hA5A5_A5A5, 32'h0, 1);
    txn(1, 1, 0, 32'h0000_0008, 32'h0,         32'hA5A5_A5A5, 0);

    // LATENCY=7: write then held back-to-back reads.
    txn(2, 0, 1, 32'h0000_0010, 32'h0BAD_CAFE, 32'h0, 0);
    txn(2, 1, 0, 32'h0000_0010, 32'h0,         32'h0BAD_CAFE, 0);
    txn(2, 1, 0, 32'h0000_0010, 32'h0,         32'h0BAD_CAFE, 0);

    // LATENCY=4: reset while in WAIT, request held across reset.
    txn(3, 0, 1, 32'h0000_0014, 32'h7777_8888, 32'h0, 0);
    r_v[3]    = 1'b1;
    w_v[3]    = 1'b0;
    addr_a[3] = 32'h0000_0014;
    repeat (2) @(negedge clk);
    rst_n[3] = 1'b0;
    @(negedge clk);
    chk("rstwait_resp", {31'b0, resp[3]}, 32'h0);
    chk("rstwait_data", rd_a[3], 32'h0);
    chk("rstwait_err",  {31'b0, err[3]},  32'h0);
    @(negedge clk);
    rst_n[3]  = 1'b1;
    hold_m[3] = '0;
    err_m[3]  = 1'b0;
    wait_resp(3, 1'b1, 32'h7777_8888, 1'b0);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
